// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - decoupled instruction fetch queue with redirect flush
// Issues sequential fetches, buffers {pc, instr} pairs and drops stale responses after a redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   CAP     = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [63:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [63:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic [CW:0]   in_use;
  logic          accept, rsp_take, push, pop;
  logic [63:0]   target_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[63:2], 2'b00};

  // Entries held plus requests in flight never exceed DEPTH, so a response always has a slot.
  assign in_use        = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid = reset & ~redirect & (in_use < CAP);
  assign mem_req_addr  = reset ? fetch_pc : RESET_PC;
  assign accept        = mem_req_valid & mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take  = mem_rsp_valid & (outstanding != '0);
  assign push      = rsp_take & (discard == '0) & ~redirect;
  assign out_valid = reset & (count != '0);
  assign pop       = out_valid & ~stall & ~redirect;
  assign out_pc    = out_valid ? pc_q[rd_ptr] : 64'h0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : NOP;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc    <= target_pc;
      rsp_pc      <= target_pc;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding - CW'(rsp_take);
      discard     <= outstanding - CW'(rsp_take);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
      if (rsp_take && discard != '0) begin
        discard <= discard - 1'b1;
      end
      if (push) begin
        rsp_pc <= rsp_pc + 64'd4;
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_q[wr_ptr]    <= rsp_pc;
      instr_q[wr_ptr] <= mem_rsp_data;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) push |-> (count != DEPTH_C));

endmodule
